program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Writer side of the 16x8 instruction memory that the accumulator processor fetches from.
//  - Accepts a byte stream over a valid/ready handshake and stores it at addresses 0..N-1.
//  - Pads the unwritten tail with HLT, then releases the core.
//  - Holds the core via cpu_pause while loading and serves its fetch port with zero latency.
// PARAMETERS
//  DEPTH       16     instruction words in memory
//  AW          4      address width, log2(DEPTH)
//  DW          8      instruction width
//  HLT_OPCODE  8'hFF  pad word written to unloaded slots
// PORTS
//  clk         in   1      system clock, rising edge
//  rstn        in   1      asynchronous active-low reset
//  start       in   1      1-cycle request to begin a (re)load
//  in_valid    in   1      in_data/in_last valid
//  in_data     in   DW     instruction byte
//  in_last     in   1      marks the final byte of the program
//  in_ready    out  1      loader accepts a byte this cycle
//  fetch_addr  in   AW     core fetch address (PC)
//  fetch_data  out  DW     mem[fetch_addr], combinational
//  cpu_pause   out  1      1 = core must hold PC/IR
//  cpu_start   out  1      1-cycle pulse on entry to RUN
//  load_done   out  1      1 while in RUN
//  load_count  out  AW+1   bytes accepted in the current load, 0..DEPTH
//  overflow_err out 1      DEPTH bytes accepted without in_last; sticky until next start
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE, all mem words=8'h00 (NOP), wr_ptr=0, load_count=0.
//   - cpu_pause=1, in_ready=0, cpu_start=0, load_done=0, overflow_err=0.
//  States: IDLE, LOAD, FILL, RUN. All outputs are registered/decoded from state; no output depends on in_valid.
//  IDLE:
//   - in_ready=0, cpu_pause=1.
//   - start -> LOAD; clear wr_ptr, load_count, overflow_err.
//  LOAD:
//   - in_ready=1, cpu_pause=1.
//   - Accept = in_valid & in_ready: mem[wr_ptr]<=in_data, wr_ptr++, load_count++.
//   - Accept with in_last=1 and wr_ptr<DEPTH-1 -> FILL.
//   - Accept at wr_ptr==DEPTH-1 -> RUN, whatever in_last is. If in_last=0, set overflow_err=1.
//   - Ignored in LOAD: in_valid=0 cycles (no state change); start.
//  FILL:
//   - in_ready=0, cpu_pause=1.
//   - One slot per cycle: mem[wr_ptr]<=HLT_OPCODE, wr_ptr++.
//   - The write to slot DEPTH-1 -> RUN on the same edge.
//   - load_count frozen.
//   - start ignored.
//  RUN:
//   - in_ready=0, cpu_pause=0, load_done=1.
//   - cpu_start=1 for exactly the first RUN cycle.
//   - start -> LOAD next edge; cpu_pause=1, load_done=0 from that cycle.
//   - Memory is not cleared on reload; unwritten slots get HLT via FILL.
//  fetch_data:
//   - = mem[fetch_addr] in every state.
//   - A write and a read to the same address in one cycle returns the old word; the new word appears after the edge.
//  Latency:
//   - Last byte accepted at edge E with count K<DEPTH: FILL at E, RUN after E+(DEPTH-K).
//   - Last byte accepted with K=DEPTH: RUN after E.
//  wr_ptr is AW+1 bits internally; it never wraps; there are no writes beyond DEPTH-1.
//  Reset mid-LOAD or mid-FILL aborts immediately to reset values; partial program discarded.
// TESTING
//  1 Reset: in_ready=0, cpu_pause=1, load_done=0; fetch_data=00 for addr 0..15.
//  2 start; bytes 91,61,15,16,A7,FF, last on FF:
//     - load_count=6, FILL 10 cycles, then cpu_pause=0 and one cpu_start pulse.
//     - fetch 0..5 = program bytes, 6..15 = FF.
//  3 16 bytes 00..0F, in_last on 16th:
//     - RUN the edge after the 16th accept, no FILL, overflow_err=0.
//     - Repeat with in_last=0: overflow_err=1.
//  4 Back-pressure: in_valid random 50%, plus pulses in IDLE/RUN and start pulses in LOAD:
//     - only LOAD accepts are written, order is preserved, extra start ignored.
//  5 rstn low after 3 accepts: all outputs and mem return to reset values; next start reloads from addr 0.
//  6 start in RUN, reload 2 bytes 1F,FF with last:
//     - cpu_pause=1 the cycle after start.
//     - fetch 0,1 = 1F,FF; 2..15 = FF; RUN re-entered after 14 FILL cycles.

Source files
------------

// File: rtl/program_loader.sv
// Writer side of the instruction memory: loads a byte stream, pads the tail with HLT,
// then releases the core. The fetch port reads the memory combinationally.
module program_loader #(
    parameter int unsigned    DEPTH      = 16,
    parameter int unsigned    AW         = 4,
    parameter int unsigned    DW         = 8,
    parameter logic [DW-1:0]  HLT_OPCODE = 8'hFF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic [AW-1:0] fetch_addr,
    output logic [DW-1:0] fetch_data,
    output logic          cpu_pause,
    output logic          cpu_start,
    output logic          load_done,
    output logic [AW:0]   load_count,
    output logic          overflow_err
);

    localparam int unsigned    CW        = AW + 1;
    localparam logic [CW-1:0]  LAST_SLOT = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        RUN  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            cpu_start_q, cpu_start_d;
    logic            in_ready_q, in_ready_d;
    logic            cpu_pause_q, cpu_pause_d;
    logic            load_done_q, load_done_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic            we;
    logic [DW-1:0]   wdata;
    logic [AW-1:0]   waddr;

    // Next-state, write-port and output decode
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        cpu_start_d = 1'b0;
        we          = 1'b0;
        wdata       = '0;
        waddr       = wr_ptr_q[AW-1:0];

        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    we       = 1'b1;
                    wdata    = in_data;
                    wr_ptr_d = wr_ptr_q + CW'(1);
                    cnt_d    = cnt_q + CW'(1);
                    if (wr_ptr_q == LAST_SLOT) begin
                        // Memory full: run regardless of in_last, flag a missing terminator
                        state_d     = RUN;
                        cpu_start_d = 1'b1;
                        ovf_d       = ~in_last;
                    end else if (in_last) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                we       = 1'b1;
                wdata    = HLT_OPCODE;
                wr_ptr_d = wr_ptr_q + CW'(1);
                if (wr_ptr_q == LAST_SLOT) begin
                    state_d     = RUN;
                    cpu_start_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == LOAD);
        cpu_pause_d = (state_d != RUN);
        load_done_d = (state_d == RUN);
    end

    // State, control and memory registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            cpu_start_q <= 1'b0;
            in_ready_q  <= 1'b0;
            cpu_pause_q <= 1'b1;
            load_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            cpu_start_q <= cpu_start_d;
            in_ready_q  <= in_ready_d;
            cpu_pause_q <= cpu_pause_d;
            load_done_q <= load_done_d;
            if (we) begin
                mem_q[waddr] <= wdata;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign cpu_pause    = cpu_pause_q;
    assign cpu_start    = cpu_start_q;
    assign load_done    = load_done_q;
    assign load_count   = cnt_q;
    assign overflow_err = ovf_q;
    assign fetch_data   = mem_q[fetch_addr];

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a transaction-level
// model of the instruction memory contents and load timing.
module tb_program_loader;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [3:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       cpu_pause;
    logic       cpu_start;
    logic       load_done;
    logic [4:0] load_count;
    logic       overflow_err;

    int         n_checks = 0;
    int         n_errors = 0;

    logic [7:0] mdl_mem [DEPTH];
    logic [7:0] prog_q [$];

    program_loader dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .fetch_addr   (fetch_addr),
        .fetch_data   (fetch_data),
        .cpu_pause    (cpu_pause),
        .cpu_start    (cpu_start),
        .load_done    (load_done),
        .load_count   (load_count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            fetch_addr = 4'(a);
            #1;
            check(tag, int'(fetch_data), int'(mdl_mem[a]));
        end
    endtask

    // Valid pulses while not loading must never be written
    task automatic noise(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk);
            #1;
            check("noise_ready", int'(in_ready), 0);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ld_ready", int'(in_ready), 1);
        check("ld_pause", int'(cpu_pause), 1);
        check("ld_done", int'(load_done), 0);
        check("ld_count", int'(load_count), 0);
        check("ld_ovf", int'(overflow_err), 0);
        check("ld_cstart", int'(cpu_start), 0);
    endtask

    // One accepted byte, optionally preceded by idle cycles carrying stray start pulses
    task automatic feed_byte(input int idx, input logic [7:0] d, input logic last, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
                start    = 1'($urandom);
                in_data  = 8'($urandom);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        @(negedge clk);
        start      = 1'b0;
        in_valid   = 1'b1;
        in_data    = d;
        in_last    = last;
        fetch_addr = 4'(idx);
        #1;
        check("rdw_old", int'(fetch_data), int'(mdl_mem[idx]));
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        mdl_mem[idx] = d;
        check("wr_new", int'(fetch_data), int'(d));
        check("count", int'(load_count), idx + 1);
    endtask

    task automatic run_load(input bit last_on_final, input bit gaps);
        int  k;
        int  n;
        bit  exp_ovf;
        k = prog_q.size();
        start_pulse();
        for (int i = 0; i < k; i++) begin
            feed_byte(i, prog_q[i], (i == k - 1) ? last_on_final : 1'b0, gaps);
        end
        for (int j = k; j < DEPTH; j++) mdl_mem[j] = 8'hFF;
        exp_ovf = (k == DEPTH) && !last_on_final;
        n = 0;
        while (load_done !== 1'b1 && n < 40) begin
            check("fill_pause", int'(cpu_pause), 1);
            check("fill_ready", int'(in_ready), 0);
            check("fill_count", int'(load_count), k);
            @(posedge clk);
            #1;
            n++;
        end
        check("fill_cycles", n, DEPTH - k);
        check("run_cstart", int'(cpu_start), 1);
        check("run_pause", int'(cpu_pause), 0);
        check("run_ready", int'(in_ready), 0);
        check("run_count", int'(load_count), k);
        check("run_ovf", int'(overflow_err), int'(exp_ovf));
        @(posedge clk);
        #1;
        check("cstart_pulse", int'(cpu_start), 0);
        check("run_done", int'(load_done), 1);
        check_mem("run_mem");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        fetch_addr = 4'h0;
        for (int a = 0; a < DEPTH; a++) mdl_mem[a] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", int'(in_ready), 0);
        check("rst_pause", int'(cpu_pause), 1);
        check("rst_done", int'(load_done), 0);
        check("rst_cstart", int'(cpu_start), 0);
        check("rst_count", int'(load_count), 0);
        check_mem("rst_mem");
        @(negedge clk);
        rstn = 1'b1;
        noise(3);
        check_mem("idle_mem");

        // Fixed program with HLT padding
        prog_q = '{8'h91, 8'h61, 8'h15, 8'h16, 8'hA7, 8'hFF};
        run_load(1'b1, 1'b0);
        noise(3);
        check_mem("run_noise_mem");

        // Full memory, with and without terminator
        prog_q.delete();
        for (int i = 0; i < DEPTH; i++) prog_q.push_back(8'(i));
        run_load(1'b1, 1'b0);
        run_load(1'b0, 1'b1);

        // Randomized programs with back-pressure and stray starts
        for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(1, DEPTH);
            prog_q.delete();
            for (int i = 0; i < len; i++) prog_q.push_back(8'($urandom));
            run_load((len < DEPTH) ? 1'b1 : 1'($urandom), 1'b1);
            noise($urandom_range(0, 3));
        end

        // Reset during a load
        start_pulse();
        for (int i = 0; i < 3; i++) feed_byte(i, 8'($urandom), 1'b0, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        for (int a = 0; a < DEPTH; a++) mdl_mem[a] = 8'h00;
        check("arst_ready", int'(in_ready), 0);
        check("arst_pause", int'(cpu_pause), 1);
        check("arst_done", int'(load_done), 0);
        check("arst_count", int'(load_count), 0);
        check("arst_ovf", int'(overflow_err), 0);
        check_mem("arst_mem");
        @(negedge clk);
        rstn = 1'b1;
        prog_q = '{8'h3C, 8'h5A, 8'hC3};
        run_load(1'b1, 1'b1);

        // Reload from RUN
        prog_q = '{8'h1F, 8'hFF};
        run_load(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
